// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC generator, one-deep in-flight tracker and
// instruction FIFO feeding the decode stage over valid/ready.
// Optional build macro FETCH_PERF_CNT_EN adds push/flush perf counters.
module inst_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [XLEN-1:0]        inst_out,
  output logic [XLEN-1:0]        inst_pc,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   halt,
  output logic                   is_halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_flushed
`else
  output logic [$clog2(DEPTH):0] occupancy
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]            fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]            issued_pc_q;
  logic                       in_flight_q;
  logic                       halt_sticky_q;
  logic [CW-1:0]              count_q, count_d;
  logic [AW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [DEPTH-1:0][XLEN-1:0] inst_mem_q, pc_mem_q;
  logic                       room, push, pop;

  // Target low bits are dropped: fetch is always word aligned.
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Per-cycle request / push / pop decisions and next PC / count
  always_comb begin
    room       = (32'(count_q) + 32'(in_flight_q)) < DEPTH;
    imem_req   = !reset && !halt_sticky_q && !halt && !redirect_valid && room;
    inst_valid = (count_q != '0) && !redirect_valid;
    // A response landing in a redirect cycle belongs to the old path.
    push       = in_flight_q && !redirect_valid;
    pop        = inst_valid && inst_ready;

    count_d = count_q;
    if (redirect_valid)    count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (imem_req)  fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  assign imem_addr = fetch_pc_q;
  assign inst_out  = inst_mem_q[rd_ptr_q];
  assign inst_pc   = pc_mem_q[rd_ptr_q];
  assign occupancy = count_q;
  assign is_halted = halt_sticky_q && (count_q == '0) && !in_flight_q;

  // Fetch PC, in-flight tracker and sticky halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      issued_pc_q   <= '0;
      in_flight_q   <= 1'b0;
      halt_sticky_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= imem_req;
      if (imem_req) issued_pc_q <= fetch_pc_q;
      if (halt)     halt_sticky_q <= 1'b1;
    end
  end

  // FIFO storage and pointers; a redirect flushes by rewinding both pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inst_mem_q <= '0;
      pc_mem_q   <= '0;
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          inst_mem_q[wr_ptr_q] <= imem_rdata;
          pc_mem_q[wr_ptr_q]   <= issued_pc_q;
          wr_ptr_q             <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;

  // Count FIFO pushes and every entry (queued or arriving) a redirect discards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push)           perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid) perf_flushed_q <= perf_flushed_q + 32'(count_q) + 32'(in_flight_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_inst_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] KEY      = 32'h13;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        is_halted;
  logic [2:0]  occupancy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .is_halted(is_halted),
`ifdef FETCH_PERF_CNT_EN
    .occupancy(occupancy), .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`else
    .occupancy(occupancy)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of {inst, pc}, fetch PC, pending response, halt flag
  logic [63:0] q[$];
  logic [31:0] m_pc, m_ipc;
  bit          m_infl, m_hs;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_fetched, m_flushed;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = RESET_PC; m_ipc = '0; m_infl = 1'b0; m_hs = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    m_fetched = '0; m_flushed = '0;
`endif
  endtask

  task automatic compare_all(output bit ereq);
    bit evld;
    ereq = !reset && !m_hs && !halt && !redirect_valid && ((q.size() + int'(m_infl)) < DEPTH);
    evld = (q.size() != 0) && !redirect_valid;
    chk("imem_req", 32'(imem_req), 32'(ereq));
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(evld));
    if (evld) begin
      chk("inst_out", inst_out, q[0][63:32]);
      chk("inst_pc", inst_pc, q[0][31:0]);
    end
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("is_halted", 32'(is_halted), 32'(m_hs && q.size() == 0 && !m_infl));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  task automatic model_step(input bit ereq);
    if (redirect_valid) begin
`ifdef FETCH_PERF_CNT_EN
      m_flushed = m_flushed + 32'(q.size()) + 32'(m_infl);
`endif
      q.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (q.size() != 0 && inst_ready) void'(q.pop_front());
      if (m_infl) begin
        q.push_back({m_ipc ^ KEY, m_ipc});
`ifdef FETCH_PERF_CNT_EN
        m_fetched = m_fetched + 32'd1;
`endif
      end
    end
    if (ereq) begin
      m_ipc = m_pc;
      m_pc  = m_pc + 32'd4;
    end
    m_infl = ereq;
    if (halt) m_hs = 1'b1;
  endtask

  // One clock: check at negedge, advance model, answer the memory after the edge
  task automatic cycle();
    bit          ereq;
    logic        rreq;
    logic [31:0] raddr;
    @(negedge clk);
    compare_all(ereq);
    rreq  = imem_req;
    raddr = imem_addr;
    if (!reset) model_step(ereq);
    @(posedge clk);
    #1;
    imem_rdata = rreq ? (raddr ^ KEY) : $urandom();
  endtask

  task automatic hard_reset();
    reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0;
    #1;
    model_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_halted", 32'(is_halted), 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    inst_ready = 1'b0; redirect_pc = '0; imem_rdata = '0;
    hard_reset();

    // Streaming with decode always ready
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("tp1_addr", imem_addr, 32'(4 * k));
      chk("tp1_valid", 32'(inst_valid), 32'(k >= 2));
      if (k >= 2) chk("tp1_pc", inst_pc, 32'(4 * (k - 2)));
      cycle();
    end

    // Decode stalled: FIFO fills to DEPTH, then a single pop
    inst_ready = 1'b0;
    hard_reset();
    repeat (8) cycle();
    #2;
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_req", 32'(imem_req), 32'd0);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    #2;
    chk("refill_req", 32'(imem_req), 32'd1);
    chk("refill_addr", imem_addr, 32'h10);
    chk("refill_head", inst_pc, 32'h4);
    repeat (3) cycle();

    // Ten pushes, then redirect with 3 queued + 1 in flight
    inst_ready = 1'b1;
    hard_reset();
    repeat (9) cycle();
    inst_ready = 1'b0;
    repeat (2) cycle();
    #2;
    chk("pre_redir_occ", 32'(occupancy), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    #2;
    chk("redir_occ", 32'(occupancy), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_10", perf_fetched, 32'd10);
    chk("perf_flushed_4", perf_flushed, 32'd4);
`endif
    inst_ready = 1'b1;
    repeat (2) cycle();
    #2;
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_valid", 32'(inst_valid), 32'd1);
    repeat (3) cycle();

    // Halt with 2 queued + 1 in flight, decode ready
    inst_ready = 1'b0;
    hard_reset();
    repeat (3) cycle();
    halt = 1'b1; inst_ready = 1'b1;
    cycle();
    halt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("halt_drain_valid", 32'(inst_valid), 32'd1);
      chk("halt_no_req", 32'(imem_req), 32'd0);
      cycle();
    end
    #2;
    chk("halted", 32'(is_halted), 32'd1);
    repeat (4) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    cycle();
    redirect_valid = 1'b0;
    #2;
    chk("halted_redir_addr", imem_addr, 32'h40);
    chk("halted_redir_req", 32'(imem_req), 32'd0);
    repeat (2) cycle();

    // Reset in the middle of a busy stream
    inst_ready = 1'b0;
    hard_reset();
    repeat (4) cycle();
    #2;
    chk("mid_occ", 32'(occupancy), 32'd3);
    hard_reset();
    inst_ready = 1'b1;
    #2;
    chk("restart_addr", imem_addr, RESET_PC);
    chk("restart_req", 32'(imem_req), 32'd1);
    repeat (4) cycle();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) hard_reset();
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom();
      halt           = (i % 150 > 120) && ($urandom_range(0, 39) == 0);
      cycle();
    end
    redirect_valid = 1'b0; halt = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
